// File: rtl/bcd_updown_counter.sv
// N-digit synchronous BCD up/down counter with enable, parallel load,
// and wrap or saturate behaviour at the terminal value.
module bcd_updown_counter #(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] clamped;
    logic                all_nine;
    logic                all_zero;
    logic                term;
    logic                carry;
    logic [3:0]          dig;

    always_comb begin
        stepped  = count_q;
        clamped  = '0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            // carry means every lower digit sits at its rollover value
            if (carry) begin
                if (up) stepped[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else    stepped[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry = carry & (up ? (dig == 4'd9) : (dig == 4'd0));
            clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9
                                                            : load_val[4*i +: 4];
        end
    end

    assign term = up ? all_nine : all_zero;
    assign tc   = en & ~load & term;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (load) begin
            count_d = clamped;
        end else if (en) begin
            ovf_d = term;
            if (!(term && SATURATE != 0)) count_d = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed table, corner sequences and
// randomized stimulus against a decimal-integer reference model.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] lv = '0;

    logic [7:0]  c2, c2s;
    logic [15:0] c4;
    logic        tc2, tc2s, tc4, o2, o2s, o4;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(0)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(lv[7:0]), .count(c2), .tc(tc2), .ovf(o2));
    bcd_updown_counter #(.DIGITS(2), .SATURATE(1)) u2s (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(lv[7:0]), .count(c2s), .tc(tc2s), .ovf(o2s));
    bcd_updown_counter #(.DIGITS(4), .SATURATE(0)) u4 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(lv), .count(c4), .tc(tc4), .ovf(o4));

    int nvec = 0;
    int nerr = 0;

    int ndig [3] = '{2, 2, 4};
    int nsat [3] = '{0, 1, 0};
    int m    [3] = '{0, 0, 0};

    typedef struct {
        logic       rst, ld, en, up;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       tc, ovf;
    } vec_t;

    function automatic int maxv(int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [15:0] to_bcd(int v, int d);
        logic [15:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clampv(logic [15:0] x, int d);
        int v = 0;
        int p = 1;
        int dd;
        for (int i = 0; i < d; i++) begin
            dd = int'(x[4*i +: 4]);
            if (dd > 9) dd = 9;
            v = v + dd * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cnt_of(int k);
        case (k)
            0:       return {8'h00, c2};
            1:       return {8'h00, c2s};
            default: return c4;
        endcase
    endfunction

    function automatic logic tc_of(int k);
        case (k)
            0:       return tc2;
            1:       return tc2s;
            default: return tc4;
        endcase
    endfunction

    function automatic logic ovf_of(int k);
        case (k)
            0:       return o2;
            1:       return o2s;
            default: return o4;
        endcase
    endfunction

    // drive at negedge, check tc before the edge, count/ovf after it
    task automatic apply(input logic r, input logic l, input logic e,
                         input logic u, input logic [15:0] v,
                         output logic tc_pre);
        int  n [3];
        logic o [3];
        int  mx;
        logic exp_tc;
        @(negedge clk);
        reset_n = r; load = l; en = e; up = u; lv = v;
        #1;
        tc_pre = tc2;
        for (int k = 0; k < 3; k++) begin
            mx = maxv(ndig[k]);
            exp_tc = e & ~l & (u ? (m[k] == mx) : (m[k] == 0));
            check($sformatf("tc[%0d]", k), {15'b0, tc_of(k)}, {15'b0, exp_tc});
            o[k] = 1'b0;
            n[k] = m[k];
            if (r) n[k] = 0;
            else if (l) n[k] = clampv(v, ndig[k]);
            else if (e) begin
                if (u) begin
                    if (m[k] == mx) begin
                        o[k] = 1'b1;
                        n[k] = nsat[k] != 0 ? mx : 0;
                    end else n[k] = m[k] + 1;
                end else begin
                    if (m[k] == 0) begin
                        o[k] = 1'b1;
                        n[k] = nsat[k] != 0 ? 0 : mx;
                    end else n[k] = m[k] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m[k] = n[k];
            check($sformatf("count[%0d]", k), cnt_of(k), to_bcd(m[k], ndig[k]));
            check($sformatf("ovf[%0d]", k), {15'b0, ovf_of(k)}, {15'b0, o[k]});
        end
    endtask

    initial begin
        vec_t tbl [20];
        logic t;
        int   r;

        tbl[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 8'h47, 8'h47, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 8'h55, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 8'hAF, 8'h99, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 1};
        tbl[5]  = '{0, 1, 0, 0, 8'h19, 8'h19, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 8'h00, 8'h20, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 8'h00, 8'h19, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 8'h00, 8'h18, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 8'h00, 8'h18, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 8'h00, 8'h18, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 8'h00, 8'h18, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 8'h10, 8'h10, 0, 0};
        tbl[13] = '{0, 0, 1, 0, 8'h00, 8'h09, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 8'h01, 8'h01, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        tbl[16] = '{0, 0, 1, 0, 8'h00, 8'h99, 1, 1};
        tbl[17] = '{0, 0, 0, 0, 8'h00, 8'h99, 0, 0};
        tbl[18] = '{1, 0, 1, 1, 8'h00, 8'h00, 1, 0};
        tbl[19] = '{0, 1, 0, 0, 8'h3C, 8'h39, 0, 0};

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].rst, tbl[i].ld, tbl[i].en, tbl[i].up,
                  {8'h00, tbl[i].lv}, t);
            check($sformatf("tbl%0d_cnt", i), {8'h00, c2}, {8'h00, tbl[i].cnt});
            check($sformatf("tbl%0d_tc", i), {15'b0, t}, {15'b0, tbl[i].tc});
            check($sformatf("tbl%0d_ovf", i), {15'b0, o2}, {15'b0, tbl[i].ovf});
        end

        // full count-up wrap on the two-digit counter
        apply(1, 0, 0, 0, 16'h0, t);
        for (int i = 0; i < 100; i++) begin
            apply(0, 0, 1, 1, 16'h0, t);
            check("up_tc_only_at_99", {15'b0, t}, {15'b0, (i == 99)});
        end
        check("up100_cnt", {8'h00, c2}, 16'h0000);
        check("up100_ovf", {15'b0, o2}, 16'h0001);

        // saturate holds at 99 and pulses ovf on each held edge
        apply(0, 1, 0, 0, 16'h0098, t);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 1, 16'h0, t);
            check("sat_cnt", {8'h00, c2s}, 16'h0099);
            check("sat_ovf", {15'b0, o2s}, {15'b0, (i != 0)});
        end

        // four-digit cascade in one edge
        apply(0, 1, 0, 0, 16'h0999, t);
        apply(0, 0, 1, 1, 16'h0, t);
        check("cascade_cnt", c4, 16'h1000);

        // randomized stimulus, biased toward loads near the terminals
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            apply(r < 2, (r >= 2 && r < 10), ($urandom_range(0, 9) < 8),
                  1'($urandom), ($urandom_range(0, 1) != 0) ?
                  16'($urandom) : (($urandom_range(0, 1) != 0) ?
                  16'h9998 : 16'h0001), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised successor to the single-digit synchronous decade counter: cascaded N-digit synchronous BCD counter with up/down, count enable, parallel load and wrap/saturate mode.
- Used wherever the design needs decimal event counts or display values, e.g. multi-digit timers and 7-segment drivers.
- All digits update on the same clk edge; no ripple clocking.

Parameters:
- DIGITS, 2, number of BCD digits, 1..8; count width is 4*DIGITS.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- reset_n  in  1  Synchronous, active-high reset (1 = reset); the port name is kept for codebase consistency.
- en  in  1  Count enable; one step per clk while high.
- up  in  1  Direction: 1 = increment, 0 = decrement.
- load  in  1  Synchronous parallel load.
- load_val  in  4*DIGITS  Value to load; digit i occupies bits [4i+3:4i], digit 0 is least significant.
- count  out  4*DIGITS  Registered BCD count.
- tc  out  1  Combinational terminal count: en & ~load & at terminal for the current direction.
- ovf  out  1  Registered one-cycle pulse: the previous edge wrapped or attempted to pass a terminal.

Behaviour:
- Reset: when reset_n=1 at a rising edge, count=0 and ovf=0. Reset overrides load and en.
- Priority at each edge: reset_n > load > en. With none active, count holds and ovf=0.
- Load:
  - count <= load_val, with each digit >9 clamped to 9 (e.g. digit value 0xC loads as 9).
  - ovf=0 on a load edge.
  - Load is honoured regardless of en.
- Up count (en=1, up=1):
  - Digit 0 steps +1.
  - Digit i>0 steps only when all lower digits are 9.
  - A digit stepping from 9 goes to 0.
- Down count (en=1, up=0):
  - Digit 0 steps -1.
  - Digit i>0 steps only when all lower digits are 0.
  - A digit stepping from 0 goes to 9.
- Terminal values: up terminal = all digits 9; down terminal = all digits 0.
- At terminal with en=1 and no load:
  - SATURATE=0: count wraps (all 9s -> 0, or 0 -> all 9s); ovf=1 next cycle.
  - SATURATE=1: count holds; ovf=1 next cycle.
- tc is asserted in the cycle before the wrapping/saturating edge, so tc can cascade into the next counter's en.
- Latency: one edge from en/load to count change; ovf is valid in the cycle after the terminal step.
- Direction change takes effect on the next edge; no extra state is kept between steps.
- Invalid digits (>9) can never appear in count.
- Reset mid-count: count clears on that edge, and any pending ovf is cleared.

Test Plan:
- DIGITS=2, SATURATE=0: reset_n=1 for 1 cycle, then en=1, up=1 for 100 cycles -> count goes 00,01..09,10..99,00; tc=1 only while count=99; ovf=1 for exactly one cycle after 99->00.
- DIGITS=2: load 0x10, then en=1, up=0 -> count 09; next edges 08..00, then 99 with ovf pulse; tc=1 while count=00.
- SATURATE=1: load 0x98, en=1, up=1 for 4 cycles -> 99, 99, 99, 99; ovf=1 on each held terminal edge after reaching 99; count never leaves 99.
- Priority:
  - load=1, en=1, load_val=0x47 -> count=47 on that edge.
  - Next cycle reset_n=1 and load=1 together -> count=00, ovf=0.
  - load_val=0xAF -> count=99 (both digits clamped).
- Mid-stream direction: count=19 with up=1, en=1 -> 20; then up=0 -> 19, 18; en=0 for 3 cycles -> count holds 18, tc=0, ovf=0.
- DIGITS=4 cascade: load 0x0999, up=1, en=1 -> 1000 in a single edge, all four digits updating simultaneously.
